// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM fader: channel fade-state encoding and default PWM width.
package led_pkg;

  localparam int unsigned PWM_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } fade_state_e;

endpackage

// File: rtl/led_pwm_fader_if.sv
// Request/step/drive bundle between the LED counter stage (master) and the fader (slave).
interface led_pwm_fader_if;

  logic [2:0] led_req;
  logic       step_tick;
  logic [2:0] led;

  modport master (output led_req, output step_tick, input led);
  modport slave  (input led_req, input step_tick, output led);

endinterface

// File: rtl/led_fade_chan.sv
// One fader channel: fade FSM, saturating level, period-aligned duty latch and registered PWM drive.
// Optional build macro LED_PWM_GAMMA_EN selects the squared brightness curve for the latched duty.
module led_fade_chan
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned STEP     = 17
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                req_i,
  input  logic                step_tick_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS:0]   MAX_W  = {1'b0, MAX};
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

  fade_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                led_q, led_d;
  logic [PWM_BITS:0]   level_ext, level_up, level_dn;

  function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] lvl);
`ifdef LED_PWM_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
    return (lvl == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
`else
    return lvl;
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    level_ext = {1'b0, level_q};
    level_up  = level_ext + STEP_W;
    level_dn  = level_ext - STEP_W;

    unique case (state_q)
      ST_OFF:        if (req_i)  state_d = ST_RISE;
      ST_RISE, ST_ON: if (!req_i) state_d = ST_FALL;
      ST_FALL:       if (req_i)  state_d = ST_RISE;
      default:       state_d = ST_OFF;
    endcase

    // The step follows the direction just chosen, so a request flip and a tick on the same edge move the new way.
    if (step_tick_i) begin
      if (state_d == ST_RISE) begin
        if (level_up >= MAX_W) begin
          level_d = MAX;
          state_d = ST_ON;
        end else begin
          level_d = level_up[PWM_BITS-1:0];
        end
      end else if (state_d == ST_FALL) begin
        if (level_ext <= STEP_W) begin
          level_d = '0;
          state_d = ST_OFF;
        end else begin
          level_d = level_dn[PWM_BITS-1:0];
        end
      end
    end
  end

  always_comb begin
    duty_d = (pwm_cnt_i == MAX) ? shape(level_q) : duty_q;
    // Full-scale duty must stay lit even on the last count of the period.
    led_d  = ((duty_q == MAX) || (pwm_cnt_i < duty_q)) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_OFF;
      level_q <= '0;
      duty_q  <= '0;
      led_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Three-channel LED fader: shared free-running PWM counter feeding three led_fade_chan instances.
// Build macro LED_PWM_GAMMA_EN (undefined by default) enables gamma-shaped duty in every channel.
module led_pwm_fader
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned STEP     = 17
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [2:0] led_req,
  input  logic       step_tick,
  output logic [2:0] led
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_d;
  end

  for (genvar i = 0; i < 3; i++) begin : g_ch
    led_fade_chan #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_chan (
      .clk         (clk),
      .res_n       (res_n),
      .req_i       (led_req[i]),
      .step_tick_i (step_tick),
      .pwm_cnt_i   (pwm_cnt_q),
      .led_o       (led[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: three step sizes driven in parallel against an arithmetic reference model.
module tb_led_pwm_fader;

  localparam int NDUT = 3;
  localparam int MAXV = 255;
  localparam int STEPS [NDUT] = '{17, 100, 64};

  logic clk   = 1'b0;
  logic res_n = 1'b1;
  always #5 clk = ~clk;

  led_pwm_fader_if bus ();

  logic [2:0] led_w   [NDUT];
  logic [7:0] lvl_mon [NDUT][3];
  logic [7:0] dty_mon [NDUT][3];
  logic [1:0] st_mon  [NDUT][3];

  assign bus.led = led_w[0];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    led_pwm_fader #(.PWM_BITS(8), .STEP(STEPS[k])) u_dut (
      .clk       (clk),
      .res_n     (res_n),
      .led_req   (bus.led_req),
      .step_tick (bus.step_tick),
      .led       (led_w[k])
    );
    for (genvar c = 0; c < 3; c++) begin : g_mon
      assign lvl_mon[k][c] = u_dut.g_ch[c].u_chan.level_q;
      assign dty_mon[k][c] = u_dut.g_ch[c].u_chan.duty_q;
      assign st_mon[k][c]  = u_dut.g_ch[c].u_chan.state_q;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: states OFF=0 RISE=1 ON=2 FALL=3
  int m_st [NDUT][3];
  int m_lvl[NDUT][3];
  int m_dty[NDUT][3];
  int m_led[NDUT][3];
  int m_cnt;

  function automatic int shape(input int l);
`ifdef LED_PWM_GAMMA_EN
    return (l == MAXV) ? MAXV : (l * l) / 256;
`else
    return l;
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int k = 0; k < NDUT; k++)
      for (int c = 0; c < 3; c++) begin
        m_st[k][c] = 0; m_lvl[k][c] = 0; m_dty[k][c] = 0; m_led[k][c] = 1;
      end
  endtask

  task automatic model_step();
    for (int k = 0; k < NDUT; k++)
      for (int c = 0; c < 3; c++) begin
        bit want;
        want = bus.led_req[c];
        m_led[k][c] = (m_dty[k][c] == MAXV || m_cnt < m_dty[k][c]) ? 0 : 1;
        if (m_cnt == MAXV) m_dty[k][c] = shape(m_lvl[k][c]);
        if (want && (m_st[k][c] == 0 || m_st[k][c] == 3)) m_st[k][c] = 1;
        if (!want && (m_st[k][c] == 1 || m_st[k][c] == 2)) m_st[k][c] = 3;
        if (bus.step_tick) begin
          if (m_st[k][c] == 1) begin
            m_lvl[k][c] = (m_lvl[k][c] + STEPS[k] > MAXV) ? MAXV : m_lvl[k][c] + STEPS[k];
            if (m_lvl[k][c] == MAXV) m_st[k][c] = 2;
          end else if (m_st[k][c] == 3) begin
            m_lvl[k][c] = (m_lvl[k][c] < STEPS[k]) ? 0 : m_lvl[k][c] - STEPS[k];
            if (m_lvl[k][c] == 0) m_st[k][c] = 0;
          end
        end
      end
    m_cnt = (m_cnt + 1) % 256;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge res_n);
      if (!res_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++)
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("d%0d.c%0d led", k, c), 32'(led_w[k][c]), 32'(m_led[k][c]));
          chk($sformatf("d%0d.c%0d level", k, c), 32'(lvl_mon[k][c]), 32'(m_lvl[k][c]));
          chk($sformatf("d%0d.c%0d state", k, c), 32'(st_mon[k][c]), 32'(m_st[k][c]));
        end
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) bus.step_tick = 1'b1;
      @(negedge clk) bus.step_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk) res_n = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic count_lit(input int k, input int c, output int n);
    n = 0;
    repeat (256) begin
      @(negedge clk);
      if (led_w[k][c] == 1'b0) n++;
    end
  endtask

  int n_lit;
`ifdef LED_PWM_GAMMA_EN
  localparam int HALF_DUTY = 64;
`else
  localparam int HALF_DUTY = 128;
`endif

  initial begin
    bus.led_req   = 3'b000;
    bus.step_tick = 1'b0;
    #1 res_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset led", 32'(led_w[0]), 32'd7);
    res_n = 1'b1;

    // Full rise on channel 0
    @(negedge clk) bus.led_req = 3'b001;
    ticks(2);
    chk("s17 lvl after 2", 32'(lvl_mon[0][0]), 32'd34);
    chk("s100 lvl after 2", 32'(lvl_mon[1][0]), 32'd200);
    chk("s64 lvl after 2", 32'(lvl_mon[2][0]), 32'd128);
    ticks(1);
    chk("s100 saturate", 32'(lvl_mon[1][0]), 32'd255);
    chk("s100 state ON", 32'(st_mon[1][0]), 32'd2);
    ticks(12);
    chk("s17 full lvl", 32'(lvl_mon[0][0]), 32'd255);
    chk("s17 state ON", 32'(st_mon[0][0]), 32'd2);
    repeat (260) @(negedge clk);
    count_lit(0, 0, n_lit);
    chk("s17 full-on lit clks", 32'(n_lit), 32'd256);

    // Fall with saturation at zero
    @(negedge clk) bus.led_req = 3'b000;
    ticks(1);
    chk("s100 fall 1", 32'(lvl_mon[1][0]), 32'd155);
    chk("s100 state FALL", 32'(st_mon[1][0]), 32'd3);
    ticks(1);
    chk("s100 fall 2", 32'(lvl_mon[1][0]), 32'd55);
    ticks(1);
    chk("s100 fall 3", 32'(lvl_mon[1][0]), 32'd0);
    chk("s100 state OFF", 32'(st_mon[1][0]), 32'd0);
    chk("s17 fall 3", 32'(lvl_mon[0][0]), 32'd204);

    // Mid-rise reversal with coincident tick on channel 1
    reset_pulse();
    @(negedge clk) bus.led_req = 3'b010;
    ticks(5);
    chk("rev lvl before", 32'(lvl_mon[0][1]), 32'd85);
    chk("rev state before", 32'(st_mon[0][1]), 32'd1);
    @(negedge clk) begin bus.led_req = 3'b000; bus.step_tick = 1'b1; end
    @(negedge clk) bus.step_tick = 1'b0;
    chk("rev state FALL", 32'(st_mon[0][1]), 32'd3);
    chk("rev lvl 68", 32'(lvl_mon[0][1]), 32'd68);
    chk("rev s100 lvl", 32'(lvl_mon[1][1]), 32'd155);

    // Half-scale duty on channel 2 of the STEP=64 instance
    reset_pulse();
    @(negedge clk) bus.led_req = 3'b100;
    ticks(2);
    chk("s64 ch2 lvl", 32'(lvl_mon[2][2]), 32'd128);
    repeat (260) @(negedge clk);
    chk("s64 ch2 duty", 32'(dty_mon[2][2]), 32'(HALF_DUTY));
    count_lit(2, 2, n_lit);
    chk("s64 ch2 lit clks", 32'(n_lit), 32'(HALF_DUTY));

    // Asynchronous reset while channel 2 is still rising
    chk("pre-reset s17 state RISE", 32'(st_mon[0][2]), 32'd1);
    @(posedge clk);
    #2 res_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("async rst d%0d led", k), 32'(led_w[k]), 32'd7);
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("async rst d%0d.c%0d lvl", k, c), 32'(lvl_mon[k][c]), 32'd0);
        chk($sformatf("async rst d%0d.c%0d st", k, c), 32'(st_mon[k][c]), 32'd0);
      end
    end
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
